// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types and sign-magnitude helpers for the accumulator
//
// Purpose: FSM state type, -0 canonicalisation and the saturated-magnitude
//          constant used by sm_accumulator.
// Ports:   none (package).
package sm_pkg;

    // Widest operand the helpers handle; callers zero-extend into this width.
    localparam int SM_MAX_W = 32;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } sm_state_e;

    // Maps a zero-magnitude value (+0 or -0) to all zeros; other values pass.
    // Only the low 'width' bits of value are meaningful.
    function automatic logic [SM_MAX_W-1:0] sm_canon(input logic [SM_MAX_W-1:0] value,
                                                     input int width);
        logic [SM_MAX_W-1:0] mag_mask;
        mag_mask = (SM_MAX_W'(1) << (width - 1)) - SM_MAX_W'(1);
        if ((value & mag_mask) == '0) begin
            return '0;
        end
        return value;
    endfunction

    // All-ones magnitude field (width-1 ones) for a 'width'-bit operand.
    function automatic logic [SM_MAX_W-1:0] sm_sat_mag(input int width);
        return (SM_MAX_W'(1) << (width - 1)) - SM_MAX_W'(1);
    endfunction

endpackage

// File: rtl/true_form_adder.sv
// rtl/true_form_adder.sv - combinational sign-magnitude (true-form) adder
//
// Purpose: adds two sign-magnitude operands.
// Ports:   a, b  in  WIDTH  operands, sign in MSB
//          sum   out WIDTH  result; an exact cancellation may carry either sign
//          of    out 1      magnitude carry out on a same-sign add
module true_form_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             of
);

    logic             sa;
    logic             sb;
    logic [WIDTH-2:0] ma;
    logic [WIDTH-2:0] mb;
    logic [WIDTH-1:0] mag_add;

    assign sa      = a[WIDTH-1];
    assign sb      = b[WIDTH-1];
    assign ma      = a[WIDTH-2:0];
    assign mb      = b[WIDTH-2:0];
    assign mag_add = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        sum = '0;
        of  = 1'b0;
        if (sa == sb) begin
            sum = {sa, mag_add[WIDTH-2:0]};
            of  = mag_add[WIDTH-1];
        end else if (ma >= mb) begin
            // Larger magnitude sets the sign; a tie yields sign of a with zero magnitude.
            sum = {sa, ma - mb};
        end else begin
            sum = {sb, mb - ma};
        end
    end

endmodule

// File: rtl/sm_accumulator.sv
// rtl/sm_accumulator.sv - frame-based sign-magnitude accumulator
//
// Purpose: sums a frame of sign-magnitude operands through true_form_adder,
//          saturating on overflow, and hands off sum/overflow/count per frame.
// Ports:   clk, rst_n                 clock, async active-low reset
//          in_valid/in_ready          operand handshake
//          in_data [WIDTH]            operand; in_last marks the frame end
//          out_valid/out_ready        result handshake
//          out_sum [WIDTH]            frame sum, never -0
//          out_of                     sticky overflow for the frame
//          out_count [COUNT_W]        operands accepted (saturating)
module sm_accumulator
    import sm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_of,
    output logic [COUNT_W-1:0] out_count
);

    sm_state_e            state_q;
    sm_state_e            state_d;
    logic [WIDTH-1:0]     acc_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 of_q;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_of;
    logic                 accept;
    logic [WIDTH-1:0]     sat_val;
    logic [WIDTH-1:0]     pre_fix;
    logic [WIDTH-1:0]     acc_d;
    // Full-width helper results; only the low WIDTH bits carry meaning.
    logic [SM_MAX_W-1:0]  sat_mag_unused;
    logic [SM_MAX_W-1:0]  canon_full_unused;

    true_form_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum),
        .of  (add_of)
    );

    assign accept = in_valid & in_ready;

    // Overflow only occurs on same-sign adds, so in_data's sign is the true sign.
    assign sat_mag_unused    = sm_sat_mag(WIDTH);
    assign sat_val           = {in_data[WIDTH-1], sat_mag_unused[WIDTH-2:0]};
    assign pre_fix           = add_of ? sat_val : add_sum;
    assign canon_full_unused = sm_canon(SM_MAX_W'(pre_fix), WIDTH);
    assign acc_d             = canon_full_unused[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= acc_d;
                of_q  <= of_q | add_of;
                if (count_q != '1) begin
                    count_q <= count_q + COUNT_W'(1);
                end
            end else if (out_valid && out_ready) begin
                acc_q   <= '0;
                count_q <= '0;
                of_q    <= 1'b0;
            end
        end
    end

    assign out_sum   = acc_q;
    assign out_of    = of_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// tb/tb_sm_accumulator.sv - self-checking bench for sm_accumulator
module tb_sm_accumulator;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int MAXMAG = (1 << (W - 1)) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_of;
    logic [CW-1:0] out_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    sm_accumulator #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_of    (out_of),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][W-1:0] ops;
        int                n;
        logic [W-1:0]      exp_sum;
        logic              exp_of;
        int                exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed integer arithmetic with saturation.
    function automatic int sm2i(input logic [W-1:0] v);
        return v[W-1] ? -int'(v[W-2:0]) : int'(v[W-2:0]);
    endfunction

    function automatic logic [W-1:0] i2sm(input int v);
        if (v < 0) return {1'b1, (W-1)'(-v)};
        return {1'b0, (W-1)'(v)};
    endfunction

    task automatic model_step(input logic [W-1:0] d, inout int acc, inout logic ofl, inout int cnt);
        int s;
        s = acc + sm2i(d);
        if (s > MAXMAG || s < -MAXMAG) begin
            ofl = 1'b1;
            acc = d[W-1] ? -MAXMAG : MAXMAG;
        end else begin
            acc = s;
        end
        if (cnt < (1 << CW) - 1) cnt++;
    endtask

    task automatic put(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("put_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [W-1:0] es, input logic eo,
                              input int ec, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 0);
        chk({tag, "_in_ready_low"}, in_ready, 0);
        repeat (stall) @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_of"}, out_of, eo);
        chk({tag, "_count"}, out_count, ec);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int acc;
        logic ofl;
        int cnt;
        int len;
        logic [W-1:0] d;

        vecs[0] = '{ops: {4'b0000, 4'b1001, 4'b0010, 4'b0011}, n: 3, exp_sum: 4'b0100, exp_of: 1'b0, exp_cnt: 3};
        vecs[1] = '{ops: {4'b0000, 4'b0000, 4'b0001, 4'b0111}, n: 2, exp_sum: 4'b0111, exp_of: 1'b1, exp_cnt: 2};
        vecs[2] = '{ops: {4'b0000, 4'b0000, 4'b0000, 4'b0001}, n: 1, exp_sum: 4'b0001, exp_of: 1'b0, exp_cnt: 1};
        vecs[3] = '{ops: {4'b0000, 4'b0000, 4'b1010, 4'b0010}, n: 2, exp_sum: 4'b0000, exp_of: 1'b0, exp_cnt: 2};
        vecs[4] = '{ops: {4'b0000, 4'b0000, 4'b0000, 4'b1000}, n: 1, exp_sum: 4'b0000, exp_of: 1'b0, exp_cnt: 1};
        vecs[5] = '{ops: {4'b0000, 4'b1111, 4'b1001, 4'b1011}, n: 3, exp_sum: 4'b1111, exp_of: 1'b1, exp_cnt: 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_of", out_of, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                put(vecs[v].ops[i], (i == vecs[v].n - 1) ? 1'b1 : 1'b0);
            end
            get_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_of, vecs[v].exp_cnt, v % 2);
        end

        // Backpressure: result 0011 held while a pending beat waits upstream.
        put(4'b0001, 1'b0);
        put(4'b0010, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0100;
        in_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, 4'b0011);
            chk("bp_count", out_count, 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_ready", in_ready, 1);
        chk("bp_after_valid", out_valid, 0);
        chk("bp_after_sum", out_sum, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_sum", out_sum, 4'b0100);
        chk("bp_held_count", out_count, 1);
        chk("bp_held_of", out_of, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Mid-frame reset discards the partial sum immediately.
        put(4'b0011, 1'b0);
        put(4'b0010, 1'b0);
        @(negedge clk);
        chk("mid_partial_sum", out_sum, 4'b0101);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        put(4'b0101, 1'b1);
        get_result("post_rst", 4'b0101, 1'b0, 1, 0);

        // Randomized frames against the integer model.
        for (int f = 0; f < 30; f++) begin
            acc = 0;
            ofl = 1'b0;
            cnt = 0;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                d = W'($urandom_range(0, (1 << W) - 1));
                model_step(d, acc, ofl, cnt);
                put(d, (i == len - 1) ? 1'b1 : 1'b0);
            end
            get_result($sformatf("rnd%0d", f), i2sm(acc), ofl, cnt, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
